// File: rtl/lv_bist_sched.sv
// Upstream scheduler for the LV logic BIST engine: settle delay, run, retry, verdict.
// Optional build macro LV_BIST_SKIP_EN adds i_bist_skip to bypass BIST with a pass verdict.
//
// state  | meaning
// IDLE   | waiting for i_pwr_ok
// DLY    | settle delay before the first attempt
// RUN    | o_bist_en high, waiting for done or watchdog
// EVAL   | one cycle to judge the latched result
// GAP    | o_bist_en low so the engine's counters clear
// DONE   | verdict held until i_pwr_ok drops
module lv_bist_sched #(
    parameter int START_DLY      = 64,
    parameter int BIST_GAP       = 4,
    parameter int BIST_RETRY_NUM = 2,
    parameter int DONE_TMO       = 120000
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_pwr_ok,
`ifdef LV_BIST_SKIP_EN
    input  logic                                  i_bist_skip,
`endif
    output logic                                  o_bist_en,
    input  logic                                  i_lv_bist_done,
    input  logic                                  i_owt_bist_rult,
    input  logic                                  i_scan_reg_bist_rult,
    input  logic                                  i_hv_intb_bist_rult,
    output logic                                  o_bist_busy,
    output logic                                  o_bist_pass,
    output logic                                  o_bist_fail,
    output logic                                  o_bist_cmplt,
    output logic [2:0]                            o_bist_rult,
    output logic                                  o_bist_tmo,
    output logic [$clog2(BIST_RETRY_NUM+2)-1:0]   o_bist_try_cnt
);
    localparam int TW     = $clog2(BIST_RETRY_NUM + 2);
    localparam int CMAX_A = (START_DLY > BIST_GAP) ? START_DLY : BIST_GAP;
    localparam int CMAX   = (CMAX_A > DONE_TMO) ? CMAX_A : DONE_TMO;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_DLY, S_RUN, S_EVAL, S_GAP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   try_q, try_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            cmplt_q, cmplt_d;
    logic [2:0]      rult_q, rult_d;
    logic            tmo_q, tmo_d;

    // One counter serves the DLY, RUN-watchdog and GAP timers; each state reloads it on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        try_d   = try_q;
        en_d    = en_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        rult_d  = rult_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (i_pwr_ok) begin
                    cnt_d  = '0;
                    try_d  = '0;
                    tmo_d  = 1'b0;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                    rult_d = 3'b000;
                    state_d = S_DLY;
`ifdef LV_BIST_SKIP_EN
                    if (i_bist_skip) begin
                        pass_d  = 1'b1;
                        rult_d  = 3'b111;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DLY: begin
                if (cnt_q == CW'(START_DLY - 1)) begin
                    state_d = S_RUN;
                    en_d    = 1'b1;
                    try_d   = TW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (i_lv_bist_done) begin
                    state_d = S_EVAL;
                    rult_d  = {i_hv_intb_bist_rult, i_scan_reg_bist_rult, i_owt_bist_rult};
                    tmo_d   = 1'b0;
                    en_d    = 1'b0;
                end else if (cnt_q == CW'(DONE_TMO - 1)) begin
                    state_d = S_EVAL;
                    rult_d  = 3'b000;
                    tmo_d   = 1'b1;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EVAL: begin
                if (&rult_q) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (try_q <= TW'(BIST_RETRY_NUM)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                    fail_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(BIST_GAP - 1)) begin
                    state_d = S_RUN;
                    en_d    = 1'b1;
                    try_d   = try_q + TW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        // Losing the supply abandons whatever is in flight, without a completion pulse.
        if (!i_pwr_ok && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            try_d   = '0;
            en_d    = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            rult_d  = 3'b000;
            tmo_d   = 1'b0;
        end

        busy_d  = (state_d == S_DLY) || (state_d == S_RUN) ||
                  (state_d == S_EVAL) || (state_d == S_GAP);
        cmplt_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            try_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            cmplt_q <= 1'b0;
            rult_q  <= 3'b000;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            try_q   <= try_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cmplt_q <= cmplt_d;
            rult_q  <= rult_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_bist_en      = en_q;
    assign o_bist_busy    = busy_q;
    assign o_bist_pass    = pass_q;
    assign o_bist_fail    = fail_q;
    assign o_bist_cmplt   = cmplt_q;
    assign o_bist_rult    = rult_q;
    assign o_bist_tmo     = tmo_q;
    assign o_bist_try_cnt = try_q;

endmodule

// File: tb/tb_lv_bist_sched.sv
// Bench for lv_bist_sched: an engine model plays out per-attempt plans; a scoreboard
// checks each verdict on o_bist_cmplt against the outcome predicted from the plan.
module tb_lv_bist_sched;
    localparam int START_DLY = 4;
    localparam int BIST_GAP  = 4;
    localparam int RETRY     = 2;
    localparam int DONE_TMO  = 50;
    localparam int NATT      = RETRY + 1;
    localparam int TW        = $clog2(RETRY + 2);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_pwr_ok = 1'b0;
    logic          i_lv_bist_done = 1'b0;
    logic          i_owt_bist_rult = 1'b0;
    logic          i_scan_reg_bist_rult = 1'b0;
    logic          i_hv_intb_bist_rult = 1'b0;
`ifdef LV_BIST_SKIP_EN
    logic          i_bist_skip = 1'b0;
`endif
    logic          o_bist_en, o_bist_busy, o_bist_pass, o_bist_fail, o_bist_cmplt, o_bist_tmo;
    logic [2:0]    o_bist_rult;
    logic [TW-1:0] o_bist_try_cnt;

    lv_bist_sched #(
        .START_DLY(START_DLY), .BIST_GAP(BIST_GAP),
        .BIST_RETRY_NUM(RETRY), .DONE_TMO(DONE_TMO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_pwr_ok(i_pwr_ok),
`ifdef LV_BIST_SKIP_EN
        .i_bist_skip(i_bist_skip),
`endif
        .o_bist_en(o_bist_en),
        .i_lv_bist_done(i_lv_bist_done),
        .i_owt_bist_rult(i_owt_bist_rult),
        .i_scan_reg_bist_rult(i_scan_reg_bist_rult),
        .i_hv_intb_bist_rult(i_hv_intb_bist_rult),
        .o_bist_busy(o_bist_busy),
        .o_bist_pass(o_bist_pass),
        .o_bist_fail(o_bist_fail),
        .o_bist_cmplt(o_bist_cmplt),
        .o_bist_rult(o_bist_rult),
        .o_bist_tmo(o_bist_tmo),
        .o_bist_try_cnt(o_bist_try_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          pass;
        logic          fail;
        logic [2:0]    rult;
        logic          tmo;
        logic [TW-1:0] try_cnt;
    } res_t;

    res_t       exp_q[$];
    int         width_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cmplt_seen = 0;
    int         att_idx = 0;
    int         plan_lat[NATT];
    logic [2:0] plan_rult[NATT];
    bit         plan_tmo[NATT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_plan(input int k, input bit tmo, input int lat, input logic [2:0] r);
        plan_tmo[k]  = tmo;
        plan_lat[k]  = lat;
        plan_rult[k] = r;
    endtask

    // Outcome from the retry rule: first all-pass attempt wins, else the last attempt decides.
    task automatic issue_expect();
        res_t r;
        r.pass = 1'b0; r.fail = 1'b1; r.rult = 3'b000; r.tmo = 1'b0; r.try_cnt = '0;
        for (int k = 0; k < NATT; k++) begin
            r.try_cnt = TW'(k + 1);
            r.tmo     = plan_tmo[k];
            r.rult    = plan_tmo[k] ? 3'b000 : plan_rult[k];
            width_q.push_back(plan_tmo[k] ? DONE_TMO : plan_lat[k]);
            if (r.rult == 3'b111) begin
                r.pass = 1'b1;
                r.fail = 1'b0;
                break;
            end
        end
        exp_q.push_back(r);
    endtask

    // Engine model: done rises after the planned number of enable cycles; flags are noise otherwise.
    always @(negedge i_clk) begin : engine
        static bit en_prev = 1'b0;
        static int cur = 0;
        static int cnt = 0;
        if (o_bist_en) begin
            if (!en_prev) begin
                cur = att_idx;
                att_idx++;
                cnt = 0;
            end
            cnt++;
            if (cur < NATT && !plan_tmo[cur] && cnt >= plan_lat[cur]) begin
                i_lv_bist_done = 1'b1;
                {i_hv_intb_bist_rult, i_scan_reg_bist_rult, i_owt_bist_rult} = plan_rult[cur];
            end else begin
                i_lv_bist_done = 1'b0;
                {i_hv_intb_bist_rult, i_scan_reg_bist_rult, i_owt_bist_rult} = 3'($urandom);
            end
        end else begin
            i_lv_bist_done = 1'b0;
            {i_hv_intb_bist_rult, i_scan_reg_bist_rult, i_owt_bist_rult} = 3'($urandom);
        end
        en_prev = o_bist_en;
    end

    always @(negedge i_clk) begin : monitor
        static bit en_prev = 1'b0;
        static bit gap_armed = 1'b0;
        static int hi_len = 0;
        static int lo_len = 0;
        res_t e;
        if (i_rst) begin
            en_prev   = 1'b0;
            gap_armed = 1'b0;
        end else begin
            chk("pass_fail_exclusive", o_bist_pass & o_bist_fail, 0);
            chk("en_implies_busy", o_bist_en & ~o_bist_busy, 0);
            if (o_bist_en) begin
                if (!en_prev) begin
                    // EVAL cycle plus BIST_GAP cycles in GAP
                    if (gap_armed) chk("gap_low_cycles", lo_len, BIST_GAP + 1);
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (en_prev) begin
                    if (width_q.size() > 0) chk("en_width", hi_len, width_q.pop_front());
                    gap_armed = 1'b1;
                    lo_len = 0;
                end
                lo_len++;
            end
            if (!o_bist_busy) gap_armed = 1'b0;
            if (o_bist_cmplt) begin
                cmplt_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmplt: got cmplt=1 expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("verdict_pass", o_bist_pass, e.pass);
                    chk("verdict_fail", o_bist_fail, e.fail);
                    chk("verdict_rult", o_bist_rult, e.rult);
                    chk("verdict_tmo", o_bist_tmo, e.tmo);
                    chk("verdict_try_cnt", o_bist_try_cnt, e.try_cnt);
                end
            end
            en_prev = o_bist_en;
        end
    end

    task automatic wait_en(input logic lvl, input string nm);
        int g;
        for (g = 0; g < 300; g++) begin
            @(negedge i_clk);
            if (o_bist_en === lvl) break;
        end
        if (g == 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no o_bist_en=%0b expected it within 300 cycles", nm, lvl);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_en"}, o_bist_en, 0);
        chk({nm, "_busy"}, o_bist_busy, 0);
        chk({nm, "_pass"}, o_bist_pass, 0);
        chk({nm, "_fail"}, o_bist_fail, 0);
        chk({nm, "_cmplt"}, o_bist_cmplt, 0);
        chk({nm, "_rult"}, o_bist_rult, 0);
        chk({nm, "_tmo"}, o_bist_tmo, 0);
        chk({nm, "_try"}, o_bist_try_cnt, 0);
    endtask

    task automatic do_run();
        int   k;
        int   start;
        res_t e;
        att_idx = 0;
        issue_expect();
        e = exp_q[$];
        start = cmplt_seen;
        i_pwr_ok = 1'b1;
        for (k = 1; k <= 200; k++) begin
            @(negedge i_clk);
            if (o_bist_en) break;
        end
        chk("start_delay", k, START_DLY + 1);
        chk("first_try_cnt", o_bist_try_cnt, 1);
        k = 0;
        while (cmplt_seen == start && k < 2000) begin
            @(negedge i_clk);
            k++;
        end
        if (cmplt_seen == start) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmplt_timeout: got no cmplt expected one within 2000 cycles");
        end
        repeat (4) begin
            @(negedge i_clk);
            chk("done_no_rerun", o_bist_en, 0);
            chk("cmplt_one_cycle", o_bist_cmplt, 0);
            chk("done_hold_pass", o_bist_pass, e.pass);
            chk("done_hold_fail", o_bist_fail, e.fail);
        end
        i_pwr_ok = 1'b0;
        @(negedge i_clk);
        check_all_zero("drop_after_done");
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got no end of test expected finish before 800us");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("idle");

        set_plan(0, 0, 16, 3'b111); set_plan(1, 0, 5, 3'b111); set_plan(2, 0, 5, 3'b111);
        do_run();
        set_plan(0, 0, 5, 3'b110); set_plan(1, 0, 8, 3'b110); set_plan(2, 0, 12, 3'b110);
        do_run();
        set_plan(0, 0, 7, 3'b011); set_plan(1, 0, 9, 3'b111); set_plan(2, 0, 3, 3'b000);
        do_run();
        set_plan(0, 1, 1, 3'b111); set_plan(1, 1, 1, 3'b111); set_plan(2, 1, 1, 3'b111);
        do_run();
        set_plan(0, 0, DONE_TMO, 3'b111); set_plan(1, 0, 2, 3'b000); set_plan(2, 0, 2, 3'b000);
        do_run();
        set_plan(0, 1, 1, 3'b000); set_plan(1, 0, 1, 3'b101); set_plan(2, 0, 1, 3'b111);
        do_run();

        // Supply loss mid-RUN, then a clean rerun.
        set_plan(0, 0, 40, 3'b111); set_plan(1, 0, 40, 3'b111); set_plan(2, 0, 40, 3'b111);
        att_idx = 0;
        i_pwr_ok = 1'b1;
        wait_en(1'b1, "abort_en_rise");
        repeat (10) @(negedge i_clk);
        i_pwr_ok = 1'b0;
        @(negedge i_clk);
        check_all_zero("abort");
        @(negedge i_clk);
        set_plan(0, 0, 6, 3'b111);
        do_run();

        // Reset while in GAP.
        set_plan(0, 0, 3, 3'b000); set_plan(1, 0, 3, 3'b111); set_plan(2, 0, 3, 3'b111);
        att_idx = 0;
        i_pwr_ok = 1'b1;
        wait_en(1'b1, "gap_rst_en_rise");
        wait_en(1'b0, "gap_rst_en_fall");
        repeat (2) @(negedge i_clk);
        chk("gap_rst_busy_before", o_bist_busy, 1);
        i_rst = 1'b1;
        i_pwr_ok = 1'b0;
        @(negedge i_clk);
        check_all_zero("gap_reset");
        i_rst = 1'b0;
        @(negedge i_clk);

`ifdef LV_BIST_SKIP_EN
        begin
            res_t r;
            r.pass = 1'b1; r.fail = 1'b0; r.rult = 3'b111; r.tmo = 1'b0; r.try_cnt = '0;
            exp_q.push_back(r);
            i_bist_skip = 1'b1;
            i_pwr_ok = 1'b1;
            @(negedge i_clk);
            chk("skip_pass", o_bist_pass, 1);
            chk("skip_en", o_bist_en, 0);
            repeat (3) begin
                @(negedge i_clk);
                chk("skip_en_hold", o_bist_en, 0);
            end
            i_pwr_ok = 1'b0;
            i_bist_skip = 1'b0;
            @(negedge i_clk);
        end
`endif

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NATT; k++) begin
                set_plan(k, ($urandom_range(0, 5) == 0), $urandom_range(1, DONE_TMO),
                         ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 6)));
            end
            do_run();
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end

        repeat (3) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
